// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered EX-stage execute unit.
// Base ALU ops complete in one cycle. RV32M multiply/divide iterate one bit
// per cycle on operand magnitudes, and the sign is fixed when the result is
// written. Divide-by-zero and signed overflow bypass the iteration.
// Optional build macro: ALU_SEQ_FAST_MUL_EN. When it is defined, all four
// multiply ops use a combinational multiplier and complete in one cycle.
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);
  localparam int CNTW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNTW-1:0] LAST    = CNTW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [XLEN-1:0] base_alu(input logic [3:0] ctl,
                                               input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    logic signed [XLEN-1:0] sx, sy;
    logic [CNTW-1:0] sh;
    sx = x;
    sy = y;
    sh = y[CNTW-1:0];
    base_alu = '0;
    case (ctl)
      4'b0000: base_alu = x & y;
      4'b0001: base_alu = x | y;
      4'b0010: base_alu = x + y;
      4'b0011: base_alu = x ^ y;
      4'b0100: base_alu = x << sh;
      4'b0101: base_alu = x >> sh;
      4'b0110: base_alu = x - y;
      4'b0111: base_alu = $unsigned(sx >>> sh);
      4'b1000: base_alu = {{(XLEN-1){1'b0}}, x == y};
      4'b1001: base_alu = {{(XLEN-1){1'b0}}, x != y};
      4'b1010: base_alu = {{(XLEN-1){1'b0}}, 1'b1};
      4'b1100: base_alu = {{(XLEN-1){1'b0}}, sx < sy};
      4'b1101: base_alu = {{(XLEN-1){1'b0}}, sx >= sy};
      4'b1110: base_alu = {{(XLEN-1){1'b0}}, x < y};
      4'b1111: base_alu = {{(XLEN-1){1'b0}}, x >= y};
      default: base_alu = '0;
    endcase
  endfunction

  // Conditional two's-complement negation used for magnitudes and sign fix-up.
  function automatic logic [XLEN-1:0] neg_if(input logic n, input logic [XLEN-1:0] x);
    return n ? -x : x;
  endfunction

`ifdef ALU_SEQ_FAST_MUL_EN
  // sel: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU. Operands are widened so that one
  // signed multiply covers all signedness combinations.
  function automatic logic [XLEN-1:0] fast_mul(input logic [1:0] sel,
                                               input logic [XLEN-1:0] x,
                                               input logic [XLEN-1:0] y);
    logic signed [2*XLEN+1:0] ex, ey, p;
    ex = {{(XLEN+2){(sel != 2'b11) & x[XLEN-1]}}, x};
    ey = {{(XLEN+2){~sel[1] & y[XLEN-1]}}, y};
    p  = ex * ey;
    return (sel == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction
`endif

  logic              accept, is_m, is_div, div_by_zero, div_ovf, div_special;
  logic              iterative, last, sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b, fast_res, calc_res;
  logic [CNTW-1:0]   count;
  logic [XLEN-1:0]   hi, lo, opr, hi_nxt, lo_nxt;
  logic [2:0]        op_r;
  logic              neg_q, neg_r;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod;

  assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
  assign out_valid = (state == DONE);
  assign busy      = (state == CALC);
  assign accept    = in_valid & in_ready;

  assign is_m        = op[4];
  assign is_div      = op[4] & op[2];
  assign div_by_zero = (b == '0);
  assign div_ovf     = ~op[0] & (a == MIN_NEG) & (b == '1);
  assign div_special = is_div & (div_by_zero | div_ovf);
`ifdef ALU_SEQ_FAST_MUL_EN
  assign iterative   = is_div & ~div_special;
`else
  assign iterative   = is_m & ~div_special;
`endif
  assign last = (count == LAST);

  // Operand signedness: div signed when op[0]=0; mul a signed except MULHU, b signed for MUL/MULH.
  assign sign_a = is_div ? (~op[0] & a[XLEN-1]) : ((op[1:0] != 2'b11) & a[XLEN-1]);
  assign sign_b = is_div ? (~op[0] & b[XLEN-1]) : (~op[1] & b[XLEN-1]);
  assign mag_a  = neg_if(sign_a, a);
  assign mag_b  = neg_if(sign_b, b);

  // Single-cycle result: base ALU, divide special cases, optional fast multiply.
  always_comb begin
    fast_res = '0;
    if (!is_m) begin
      fast_res = base_alu(op[3:0], a, b);
    end else if (div_special) begin
      if (div_by_zero) fast_res = op[1] ? a : '1;
      else             fast_res = op[1] ? '0 : a;
    end
`ifdef ALU_SEQ_FAST_MUL_EN
    else if (!op[2]) begin
      fast_res = fast_mul(op[1:0], a, b);
    end
`endif
  end

  // One iteration step (shift-add multiply or restoring divide) plus final sign fix-up.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opr} : '0);
    div_sh   = {hi, lo[XLEN-1]};
    div_diff = div_sh - {1'b0, opr};
    hi_nxt   = mul_sum[XLEN:1];
    lo_nxt   = {mul_sum[0], lo[XLEN-1:1]};
    if (op_r[2]) begin
      if (div_sh >= {1'b0, opr}) begin
        hi_nxt = div_diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = div_sh[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end
    prod = {hi_nxt, lo_nxt};
    if (neg_q) prod = -prod;
    if (op_r[2]) calc_res = op_r[1] ? neg_if(neg_r, hi_nxt) : neg_if(neg_q, lo_nxt);
    else         calc_res = (op_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // Next-state logic; DONE can accept a new op in the same cycle it is drained.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = iterative ? CALC : DONE;
      CALC: if (last) state_nxt = DONE;
      DONE: begin
        if (accept)         state_nxt = iterative ? CALC : DONE;
        else if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any op in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Iteration counter, restarted on every accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 count <= '0;
    else if (accept)         count <= '0;
    else if (state == CALC)  count <= count + CNTW'(1);
  end

  // Result and zero flag; held untouched while DONE waits for out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (accept & ~iterative) begin
      result <= fast_res;
      zero   <= (fast_res == '0);
    end else if ((state == CALC) & last) begin
      result <= calc_res;
      zero   <= (calc_res == '0);
    end
  end

  // Iteration working registers; operands latched at accept so a/b may change later.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r  <= op[2:0];
      neg_q <= sign_a ^ sign_b;
      neg_r <= sign_a;
      hi    <= '0;
      if (op[2]) begin
        lo  <= mag_a;
        opr <= mag_b;
      end else begin
        lo  <= mag_b;
        opr <= mag_a;
      end
    end else if (state == CALC) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven and randomized bench for alu_seq (XLEN=32).
module tb_alu_seq;
  localparam int XLEN = 32;
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = XLEN + 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [4:0]      op;
  logic [XLEN-1:0] a, b, result;

  int errors = 0;
  int checks = 0;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs [30];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the op definitions, using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    int s;
    logic ovf;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    s   = int'(y % 32);
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    if (!o[4]) begin
      case (o[3:0])
        4'h0: return x & y;
        4'h1: return x | y;
        4'h2: return x + y;
        4'h3: return x ^ y;
        4'h4: return x << s;
        4'h5: return x >> s;
        4'h6: return x - y;
        4'h7: return 32'(sx >>> s);
        4'h8: return {31'b0, x == y};
        4'h9: return {31'b0, x != y};
        4'hA: return 32'd1;
        4'hB: return 32'd0;
        4'hC: return {31'b0, sx < sy};
        4'hD: return {31'b0, sx >= sy};
        4'hE: return {31'b0, x < y};
        default: return {31'b0, x >= y};
      endcase
    end
    case (o[2:0])
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ovf) return x;
        return 32'(sx / sy);
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (ovf) return 32'd0;
        return 32'(sx % sy);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
    if (!o[4]) return 1;
    if (!o[2]) return ML;
    if (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at a negedge, scramble inputs after accept, wait for the result.
  task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
    int n;
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    op = 5'($urandom);
    a = $urandom;
    b = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " result"}, result, exp);
    check({name, " zero"}, {31'b0, zero}, {31'b0, exp == 32'd0});
    check({name, " latency"}, n, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int seen;
    vecs[0]  = '{5'b00000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1};
    vecs[1]  = '{5'b00001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1};
    vecs[2]  = '{5'b00010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1};
    vecs[3]  = '{5'b00011, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1};
    vecs[4]  = '{5'b00100, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1};
    vecs[5]  = '{5'b00101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1};
    vecs[6]  = '{5'b00110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1};
    vecs[7]  = '{5'b00111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1};
    vecs[8]  = '{5'b01000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 1};
    vecs[9]  = '{5'b01001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1};
    vecs[10] = '{5'b01010, 32'h1234_5678, 32'h0000_0000, 32'h0000_0001, 1};
    vecs[11] = '{5'b01011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[12] = '{5'b01100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
    vecs[13] = '{5'b01101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[14] = '{5'b01110, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1};
    vecs[15] = '{5'b01111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1};
    vecs[16] = '{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, ML};
    vecs[17] = '{5'b10000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, ML};
    vecs[18] = '{5'b10001, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, ML};
    vecs[19] = '{5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML};
    vecs[20] = '{5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
    vecs[21] = '{5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
    vecs[22] = '{5'b10101, 32'd100,       32'd7,         32'd14,        33};
    vecs[23] = '{5'b10111, 32'd100,       32'd7,         32'd2,         33};
    vecs[24] = '{5'b10100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
    vecs[25] = '{5'b10111, 32'd5,         32'd0,         32'd5,         1};
    vecs[26] = '{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[27] = '{5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
    vecs[28] = '{5'b10101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[29] = '{5'b11001, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, ML};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", {31'b0, in_ready}, 32'd1);
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", {31'b0, zero}, 32'd1);
    check("reset busy", {31'b0, busy}, 32'd0);

    for (int i = 0; i < 30; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Back-to-back base ops, one result per cycle.
    @(negedge clk);
    op = 5'b00010; a = 32'h7FFF_FFFF; b = 32'd1; in_valid = 1'b1;
    @(negedge clk);
    check("b2b add valid", {31'b0, out_valid}, 32'd1);
    check("b2b add result", result, 32'h8000_0000);
    check("b2b in_ready", {31'b0, in_ready}, 32'd1);
    op = 5'b01100; a = 32'hFFFF_FFFF; b = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b slt valid", {31'b0, out_valid}, 32'd1);
    check("b2b slt result", result, 32'd1);
    @(negedge clk);
    check("b2b drained", {31'b0, out_valid}, 32'd0);

    // Consumer stall: result held, pending op not accepted until drained.
    out_ready = 1'b0;
    run_op("stall divu", 5'b10101, 32'd100, 32'd7, 32'd14, 33);
    op = 5'b00010; a = 32'd1; b = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d result", k), result, 32'd14);
      check($sformatf("stall%0d zero", k), {31'b0, zero}, 32'd0);
      check($sformatf("stall%0d valid", k), {31'b0, out_valid}, 32'd1);
      check($sformatf("stall%0d in_ready", k), {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("after stall valid", {31'b0, out_valid}, 32'd1);
    check("after stall result", result, 32'd2);
    @(negedge clk);
    check("after stall drained", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of a DIVU iteration.
    op = 5'b10101; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("calc busy", {31'b0, busy}, 32'd1);
    check("calc in_ready", {31'b0, in_ready}, 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset in_ready", {31'b0, in_ready}, 32'd1);
    check("midreset busy", {31'b0, busy}, 32'd0);
    check("midreset result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("no stale result", seen, 32'd0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 80; i++) begin
      logic [4:0]  o;
      logic [31:0] x, y;
      o = 5'($urandom);
      x = pick();
      y = pick();
      run_op($sformatf("rand%0d op=%0h a=%0h b=%0h", i, o, x, y), o, x, y,
             model(o, x, y), model_lat(o, x, y));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
